// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the core and its program loader.
// Opcodes match the control decoder; class codes match the loader.
package rv32_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] L_TYPE = 7'b0000011;
    localparam logic [6:0] S_TYPE = 7'b0100011;
    localparam logic [6:0] B_TYPE = 7'b1100011;
    localparam logic [6:0] J_TYPE = 7'b1101111;

    localparam logic [2:0] CLS_R = 3'd0;
    localparam logic [2:0] CLS_I = 3'd1;
    localparam logic [2:0] CLS_L = 3'd2;
    localparam logic [2:0] CLS_S = 3'd3;
    localparam logic [2:0] CLS_B = 3'd4;
    localparam logic [2:0] CLS_J = 3'd5;

    typedef struct packed {
        logic [2:0]  cls;
        logic [2:0]  funct3;
        logic        f7b5;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } fields_t;

    typedef enum logic {
        ST_LOAD,
        ST_FULL
    } ld_state_e;

endpackage

// File: rtl/rv32_field_encoder.sv
// Combinational RV32I encoder: field bundle to 32-bit word.
// Flags illegal classes and odd branch/jump offsets.
module rv32_field_encoder
    import rv32_pkg::*;
(
    input  fields_t     f,
    output logic [31:0] word,
    output logic        legal,
    output logic        misaligned
);

    logic [6:0]  f7;
    logic [31:0] im;
    logic        unused_imm_hi;

    assign f7 = {1'b0, f.f7b5, 5'b00000};
    assign im = f.imm;
    assign unused_imm_hi = ^im[31:21];

    always_comb begin
        word       = '0;
        legal      = 1'b1;
        misaligned = 1'b0;
        unique case (f.cls)
            CLS_R: word = {f7, f.rs2, f.rs1, f.funct3, f.rd, R_TYPE};
            CLS_I: begin
                // Shifts carry funct7 in the top bits and a 5-bit shamt.
                if (f.funct3 == 3'b001 || f.funct3 == 3'b101)
                    word = {f7, im[4:0], f.rs1, f.funct3, f.rd, I_TYPE};
                else
                    word = {im[11:0], f.rs1, f.funct3, f.rd, I_TYPE};
            end
            CLS_L: word = {im[11:0], f.rs1, f.funct3, f.rd, L_TYPE};
            CLS_S: word = {im[11:5], f.rs2, f.rs1, f.funct3,
                           im[4:0], S_TYPE};
            CLS_B: begin
                word = {im[12], im[10:5], f.rs2, f.rs1, f.funct3,
                        im[4:1], im[11], B_TYPE};
                misaligned = im[0];
            end
            CLS_J: begin
                word = {im[20], im[10:1], im[11], im[19:12],
                        f.rd, J_TYPE};
                misaligned = im[0];
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts field bundles, encodes them and writes
// them sequentially into instruction memory.
module instr_encoder_loader
    import rv32_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [2:0]        in_funct3,
    input  logic              in_f7b5,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MEM_WORDS);

    fields_t            fields;
    logic [31:0]        word;
    logic               legal;
    logic               misaligned;
    logic               accept;
    logic               wr_fire;
    ld_state_e          state_q;
    ld_state_e          state_d;
    logic [ADDR_W:0]    acc_cnt;
    logic [ADDR_W:0]    cnt_q;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        data_q;
    logic               we_q;
    logic               err_q;

    assign fields = '{cls:    in_class,
                      funct3: in_funct3,
                      f7b5:   in_f7b5,
                      rd:     in_rd,
                      rs1:    in_rs1,
                      rs2:    in_rs2,
                      imm:    in_imm};

    rv32_field_encoder u_enc (
        .f          (fields),
        .word       (word),
        .legal      (legal),
        .misaligned (misaligned)
    );

    assign accept  = in_valid && in_ready;
    assign wr_fire = accept && legal;

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        unique case (state_q)
            ST_LOAD: begin
                in_ready = rst_n && !start && (acc_cnt < MAX_CNT);
                if (wr_fire && (acc_cnt + 1'b1 == MAX_CNT))
                    state_d = ST_FULL;
            end
            ST_FULL: in_ready = 1'b0;
            default: state_d = ST_LOAD;
        endcase
        if (start)
            state_d = ST_LOAD;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= ST_LOAD;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_ptr  <= '0;
            acc_cnt <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            we_q <= wr_fire;
            if (wr_fire) begin
                addr_q <= wr_ptr;
                data_q <= word;
            end
            // A write already on the bus finishes; only bookkeeping clears.
            if (start) begin
                wr_ptr  <= '0;
                acc_cnt <= '0;
                cnt_q   <= '0;
                err_q   <= 1'b0;
            end else begin
                if (we_q)
                    cnt_q <= cnt_q + 1'b1;
                if (wr_fire) begin
                    wr_ptr  <= wr_ptr + 1'b1;
                    acc_cnt <= acc_cnt + 1'b1;
                end
                if (accept && (!legal || misaligned))
                    err_q <= 1'b1;
            end
        end
    end

    // Reset masks the strobe so a pending write never reaches memory.
    assign imem_we    = we_q && rst_n;
    assign imem_addr  = addr_q;
    assign imem_wdata = data_q;
    assign count      = cnt_q;
    assign full       = (acc_cnt == MAX_CNT);
    assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader with a behavioural model.
// Driver pushes expected writes; a monitor pops and compares them.
module tb_instr_encoder_loader;

    localparam int MW = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_class = '0;
    logic [2:0]    in_funct3 = '0;
    logic          in_f7b5 = 1'b0;
    logic [4:0]    in_rd = '0;
    logic [4:0]    in_rs1 = '0;
    logic [4:0]    in_rs2 = '0;
    logic [31:0]   in_imm = '0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
    logic          full;
    logic          err;

    instr_encoder_loader #(.MEM_WORDS(MW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_class   (in_class),
        .in_funct3  (in_funct3),
        .in_f7b5    (in_f7b5),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .full       (full),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] word;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  m_acc = 0;
    int  m_ptr = 0;
    int  m_cnt = 0;
    bit  m_err = 0;
    bit  m_pend = 0;
    bit  exp_ready = 0;
    bit  chk_zero = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input logic [2:0] c,
        input logic [2:0] f3, input bit f7, input logic [4:0] rd,
        input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [31:0] imm);
        logic [6:0] f7v;
        f7v = f7 ? 7'h20 : 7'h00;
        case (c)
            3'd0: return {f7v, rs2, rs1, f3, rd, 7'h33};
            3'd1: begin
                if (f3 == 3'd1 || f3 == 3'd5)
                    return {f7v, imm[4:0], rs1, f3, rd, 7'h13};
                return {imm[11:0], rs1, f3, rd, 7'h13};
            end
            3'd2: return {imm[11:0], rs1, f3, rd, 7'h03};
            3'd3: return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
            3'd4: return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1],
                          imm[11], 7'h63};
            3'd5: return {imm[20], imm[10:1], imm[11], imm[19:12], rd,
                          7'h6f};
            default: return 32'h0;
        endcase
    endfunction

    task automatic step(input bit r, input bit s, input bit v,
        input logic [2:0] c, input logic [2:0] f3, input bit f7,
        input logic [4:0] rd, input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [31:0] imm,
        input logic [31:0] w);
        if (!r && m_pend) begin
            void'(exp_q.pop_back());
            m_pend = 0;
        end
        rst_n = r; start = s; in_valid = v;
        in_class = c; in_funct3 = f3; in_f7b5 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        exp_ready = r && !s && (m_acc < MW);
        @(posedge clk);
        if (!r) begin
            m_acc = 0; m_ptr = 0; m_cnt = 0; m_err = 0; m_pend = 0;
        end else begin
            if (m_pend) m_cnt++;
            m_pend = 0;
            if (s) begin
                m_acc = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
            end else if (v && exp_ready) begin
                if (c <= 3'd5) begin
                    exp_q.push_back('{addr: m_ptr, word: w});
                    m_ptr++; m_acc++; m_pend = 1;
                    if ((c == 3'd4 || c == 3'd5) && imm[0]) m_err = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
        #1;
    endtask

    task automatic bundle(input logic [2:0] c, input logic [2:0] f3,
        input bit f7, input logic [4:0] rd, input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [31:0] imm,
        input logic [31:0] w);
        step(1, 0, 1, c, f3, f7, rd, rs1, rs2, imm, w);
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_start();
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rnd_bundle(input bit legal_only);
        logic [2:0]  c;
        logic [2:0]  f3;
        bit          f7;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        c   = legal_only ? 3'($urandom_range(0, 5)) : 3'($urandom);
        f3  = 3'($urandom); f7 = 1'($urandom);
        rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        imm = $urandom;
        if (($urandom % 4) != 0) imm[0] = 1'b0;
        step(1, 0, 1, c, f3, f7, rd, rs1, rs2, imm,
             enc(c, f3, f7, rd, rs1, rs2, imm));
    endtask

    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge clk);
            chk("in_ready", 32'(in_ready), 32'(exp_ready));
            chk("imem_we", 32'(imem_we), 32'(m_pend));
            chk("count", 32'(count), 32'(m_cnt));
            chk("full", 32'(full), 32'(m_acc == MW));
            chk("err", 32'(err), 32'(m_err));
            if (chk_zero) begin
                chk("rst_addr", 32'(imem_addr), 32'h0);
                chk("rst_wdata", imem_wdata, 32'h0);
                chk_zero = 0;
            end
            if (imem_we) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_write", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("imem_addr", 32'(imem_addr), 32'(e.addr));
                    chk("imem_wdata", imem_wdata, e.word);
                end
            end
        end
    end

    initial begin : driver
        repeat (3) do_reset();
        chk_zero = 1;
        idle();

        bundle(0, 0, 0, 3, 1, 2, 0, 32'h002081B3);
        bundle(0, 0, 1, 3, 1, 2, 0, 32'h402081B3);
        idle(); idle();

        do_start();
        bundle(1, 0, 0, 1, 0, 0, 32'd5, 32'h00500093);
        bundle(3, 2, 0, 0, 1, 2, 32'd8, 32'h0020A423);
        bundle(4, 0, 0, 0, 0, 0, -32'sd4, 32'hFE000EE3);
        idle();
        do_start();
        bundle(5, 0, 0, 1, 0, 0, 32'd8, 32'h008000EF);
        idle();
        bundle(5, 0, 0, 1, 0, 0, 32'd9, 32'h008000EF);
        idle();
        do_start();
        bundle(6, 0, 0, 1, 2, 3, 32'd4, 32'h0);
        idle(); idle();
        do_start();
        idle();

        repeat (6) rnd_bundle(1);
        idle(); idle();
        do_start();
        bundle(1, 0, 0, 7, 0, 0, 32'd1, 32'h00100393);
        idle();

        bundle(0, 0, 0, 3, 1, 2, 0, 32'h002081B3);
        do_reset();
        chk_zero = 1;
        idle(); idle();

        for (int i = 0; i < 600; i++) begin
            if (($urandom % 40) == 0)
                do_reset();
            else if (($urandom % 12) == 0)
                step(1, 1, 1'($urandom), 0, 0, 0, 1, 1, 1, 0, 0);
            else if (($urandom % 4) == 0)
                idle();
            else
                rnd_bundle(($urandom % 6) != 0);
        end
        idle(); idle();
        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
